// File: rtl/aexm_muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the request side; the unit reports status and result.
interface aexm_muldiv_if #(
    parameter int DW = 32
) ();
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          kill;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          dz;

    modport master (
        output start, op, opa, opb, kill,
        input  busy, done, result, dz
    );

    modport slave (
        input  start, op, opa, opb, kill,
        output busy, done, result, dz
    );
endinterface

// File: rtl/aexm_muldiv.sv
// Iterative multiply/divide unit.
// Multiplies retire MBITS multiplier bits per cycle with shift-add into a
// 2*DW accumulator; divides use a restoring scheme, one quotient bit per
// cycle. Signed operands are reduced to magnitudes up front and the sign is
// restored in a final fix-up cycle.
module aexm_muldiv #(
    parameter int DW    = 32,
    parameter int MBITS = 4
) (
    input  logic         gclk,
    input  logic         grst,
    aexm_muldiv_if.slave bus
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] ITER_MUL = CW'(DW / MBITS);
    localparam logic [CW-1:0] ITER_DIV = CW'(DW);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHU  = 3'd2;
    localparam logic [2:0] OP_MULHSU = 3'd3;
    localparam logic [2:0] OP_IDIV   = 3'd4;
    localparam logic [2:0] OP_IDIVU  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [DW-1:0]   opa_q, opa_d;
    logic [DW-1:0]   opb_q, opb_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [DW-1:0]   result_q, result_d;
    logic            dz_q, dz_d;

    logic            is_mul, is_div;
    logic            a_sgn, b_sgn;
    logic [DW+MBITS-1:0] mul_sum;
    logic [DW:0]     rem_ext;
    logic [DW-1:0]   rem_new;
    logic            qbit;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   quo;

    // Magnitude of a value that may be two's complement signed.
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude.
    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic sgn);
        logic signed [DW-1:0] s;
        s = signed'(v);
        if (sgn && (s < 0)) begin
            return $unsigned(-s);
        end
        return v;
    endfunction

    // Conditional two's complement negation of a double-width product.
    function automatic logic [2*DW-1:0] cneg_wide(input logic [2*DW-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's complement negation of a single-width quotient.
    function automatic logic [DW-1:0] cneg(input logic [DW-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign is_mul = (op_q <= OP_MULHSU);
    assign is_div = (op_q == OP_IDIV) || (op_q == OP_IDIVU);
    assign a_sgn  = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_IDIV);
    assign b_sgn  = (op_q == OP_MULH) || (op_q == OP_IDIV);

    // Next-state and datapath computation for every state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        dz_d     = dz_q;
        mul_sum  = '0;
        rem_ext  = '0;
        rem_new  = '0;
        qbit     = 1'b0;
        prod     = '0;
        quo      = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                // A kill in the done cycle suppresses a simultaneous start.
                if (bus.start && !((state_q == S_DONE) && bus.kill)) begin
                    state_d = S_LOAD;
                    op_d    = bus.op;
                    opa_d   = bus.opa;
                    opb_d   = bus.opb;
                end
            end

            S_LOAD: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    // Multiplier and dividend both start in the low half of
                    // the accumulator, so the initial load is shared.
                    mcand_d = magnitude(opa_q, a_sgn);
                    acc_d   = {{DW{1'b0}}, magnitude(opb_q, b_sgn)};
                    neg_d   = (a_sgn & opa_q[DW-1]) ^ (b_sgn & opb_q[DW-1]);
                    if (is_mul) begin
                        cnt_d   = ITER_MUL;
                        state_d = S_RUN;
                    end else if (is_div) begin
                        cnt_d   = ITER_DIV;
                        state_d = S_RUN;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
            end

            S_RUN: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div) begin
                        // Shift one dividend bit into the partial remainder,
                        // subtract the divisor if it fits.
                        rem_ext = acc_q[2*DW-1:DW-1];
                        if (rem_ext >= {1'b0, mcand_q}) begin
                            rem_new = DW'(rem_ext - {1'b0, mcand_q});
                            qbit    = 1'b1;
                        end else begin
                            rem_new = rem_ext[DW-1:0];
                            qbit    = 1'b0;
                        end
                        acc_d = {rem_new, acc_q[DW-2:0], qbit};
                    end else begin
                        // Add multiplicand times the low MBITS multiplier
                        // digit into the high half, then shift right.
                        mul_sum = {{MBITS{1'b0}}, acc_q[2*DW-1:DW]}
                                + ({{MBITS{1'b0}}, mcand_q} * {{DW{1'b0}}, acc_q[MBITS-1:0]});
                        acc_d   = (2*DW)'({mul_sum, acc_q[DW-1:0]} >> MBITS);
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    prod    = cneg_wide(acc_q, neg_q);
                    quo     = cneg(acc_q[DW-1:0], neg_q);
                    dz_d    = 1'b0;
                    case (op_q)
                        OP_MUL:                      result_d = prod[DW-1:0];
                        OP_MULH, OP_MULHU, OP_MULHSU: result_d = prod[2*DW-1:DW];
                        OP_IDIV, OP_IDIVU: begin
                            if (mcand_q == '0) begin
                                result_d = '0;
                                dz_d     = 1'b1;
                            end else begin
                                result_d = quo;
                            end
                        end
                        default:                     result_d = '0;
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy   = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.dz     = dz_q;

endmodule

// File: tb/tb_aexm_muldiv.sv
// Self-checking bench for aexm_muldiv (DW=32, MBITS=4).
module tb_aexm_muldiv;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    aexm_muldiv_if #(.DW(32)) bus ();

    aexm_muldiv #(.DW(32), .MBITS(4)) dut (
        .gclk (clk),
        .grst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference behaviour computed with plain 64-bit arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output int lat);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        r   = '0;
        z   = 1'b0;
        p   = '0;
        lat = (o <= 3'd3) ? 10 : ((o <= 3'd5) ? 34 : 2);
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd3: begin p = sa * ub; r = p[63:32]; end
            3'd4: begin
                if (a == 32'd0) z = 1'b1;
                else begin q = sb / sa; p = q; r = p[31:0]; end
            end
            3'd5: begin
                if (a == 32'd0) z = 1'b1;
                else r = b / a;
            end
            default: ;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic k);
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = k;
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.opa   = $urandom;
        bus.opb   = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic apply(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input int elat, input logic k);
        int n;
        start_op(o, a, b, k);
        wait_done(n);
        check({name, " latency"}, 64'(n), 64'(elat));
        check({name, " result"}, 64'(bus.result), 64'(er));
        check({name, " dz"}, 64'(bus.dz), 64'(ez));
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          n;
        logic [2:0]  ro;
        logic [31:0] ra, rb, er;
        logic        ez;
        int          elat;
        logic [31:0] edges [5];

        vectors     = 0;
        miscompares = 0;
        edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFFFFFF;
        edges[3] = 32'h80000000; edges[4] = 32'h7FFFFFFF;

        tbl[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 10};
        tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 10};
        tbl[2]  = '{3'd0, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 10};
        tbl[3]  = '{3'd4, 32'h00000002, 32'hFFFFFFF9, 32'hFFFFFFFD, 1'b0, 34};
        tbl[4]  = '{3'd5, 32'h00000000, 32'd100,      32'h00000000, 1'b1, 34};
        tbl[5]  = '{3'd4, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b0, 34};
        tbl[6]  = '{3'd6, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 2};
        tbl[7]  = '{3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 2};
        tbl[8]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 10};
        tbl[9]  = '{3'd4, 32'hFFFFFFFE, 32'h00000007, 32'hFFFFFFFD, 1'b0, 34};
        tbl[10] = '{3'd5, 32'd10,       32'hFFFFFFFF, 32'h19999999, 1'b0, 34};
        tbl[11] = '{3'd4, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1, 34};
        tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 10};
        tbl[13] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 10};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = '0;
        bus.opa   = '0;
        bus.opb   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset dz", 64'(bus.dz), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            apply($sformatf("table[%0d]", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].res, tbl[i].dz, tbl[i].lat, 1'b0);
        end

        // kill asserted together with a start in IDLE must not block it.
        apply("kill in idle", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 10, 1'b1);

        // Kill during a divide, then a fresh multiply.
        apply("pre-kill mul", 3'd0, 32'd7, 32'd6, 32'h2A, 1'b0, 10, 1'b0);
        start_op(3'd4, 32'd7, 32'd100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill busy", 64'(bus.busy), 64'd0);
        check("kill done", 64'(bus.done), 64'd0);
        check("kill result held", 64'(bus.result), 64'h2A);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.opa   = 32'd9;
        bus.opb   = 32'd11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        check("post-kill mul latency", 64'(n), 64'd10);
        check("post-kill mul result", 64'(bus.result), 64'd99);

        // Back-to-back start in the done cycle.
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.opa   = 32'd1000;
        bus.opb   = 32'd1000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("back-to-back spacing", 64'(n), 64'd11);
        check("back-to-back result", 64'(bus.result), 64'd1000000);

        // kill and start together in the done cycle: no accept.
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op    = 3'd0;
        bus.opa   = 32'd2;
        bus.opb   = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("kill beats start busy", 64'(bus.busy), 64'd0);
        check("kill beats start result", 64'(bus.result), 64'd1000000);

        // Asynchronous reset between edges during RUN.
        start_op(3'd5, 32'd3, 32'd1000, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async reset busy", 64'(bus.busy), 64'd0);
        check("async reset done", 64'(bus.done), 64'd0);
        check("async reset result", 64'(bus.result), 64'd0);
        check("async reset dz", 64'(bus.dz), 64'd0);
        #1;
        rst = 1'b0;
        apply("after reset", 3'd5, 32'd3, 32'd1000, 32'd333, 1'b0, 34, 1'b0);

        // Randomised operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
            model(ro, ra, rb, er, ez, elat);
            apply($sformatf("rand[%0d] op%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb, er, ez, elat, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aexm_muldiv.md
AEXM_MULDIV -- requirements
Module: aexm_muldiv

Interface
REQ-001 Parameter DW, default 32: operand and result width; SHALL be even and >= 8.
REQ-002 Parameter MBITS, default 4: multiplier bits retired per cycle; SHALL divide DW exactly.
REQ-003 gclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 grst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only when state is IDLE or DONE.
REQ-006 op  input  3  operation: 0 MUL (low), 1 MULH (s x s), 2 MULHU (u x u), 3 MULHSU (opa signed, opb unsigned), 4 IDIV (signed), 5 IDIVU (unsigned), 6-7 reserved.
REQ-007 opa  input  DW  multiplicand, or divisor for IDIV/IDIVU.
REQ-008 opb  input  DW  multiplier, or dividend for IDIV/IDIVU.
REQ-009 kill  input  1  abort of the operation in flight (pipeline flush or skip).
REQ-010 busy  output  1  high in states LOAD, RUN and FIX; used by the pipeline as a stall request.
REQ-011 done  output  1  single-cycle pulse; result and dz are valid while it is high.
REQ-012 result  output  DW  product word or quotient; held until the next accepted start.
REQ-013 dz  output  1  divide-by-zero flag for the last completed divide.

Function
REQ-014 States SHALL be IDLE, LOAD, RUN, FIX and DONE.
REQ-015 Accepted start SHALL register op, opa and opb and enter LOAD.
REQ-016 Inputs SHALL be ignored outside the accept cycle.
REQ-017 LOAD SHALL convert signed operands to magnitudes, record the result sign and set the iteration count ITER: DW/MBITS for ops 0-3, DW for ops 4-5.
REQ-018 LOAD SHALL then enter RUN.
REQ-019 RUN SHALL perform one iteration per cycle and enter FIX after ITER iterations.
REQ-020 Multiply SHALL use a shift-add scheme retiring MBITS multiplier bits per cycle into a 2*DW-bit accumulator.
REQ-021 Divide SHALL use a restoring scheme producing one quotient bit per cycle.
REQ-022 FIX SHALL apply the sign correction and select the result (low DW bits for op 0, high DW bits for ops 1-3, quotient for ops 4-5), then enter DONE.
REQ-023 Latency: for start accepted at edge T, done SHALL be high in the cycle following edge T+ITER+2.
REQ-024 Example latency, DW=32 and MBITS=4: T+10 for multiply, T+34 for divide.
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE; a start in DONE goes to LOAD instead (back-to-back).
REQ-026 Signed divide SHALL truncate toward zero.
REQ-027 Signed divide SHALL give the remainder's sign to the dividend; the remainder is not output.
REQ-028 Divisor zero on op 4 or 5 SHALL give result 0 and dz=1, with unchanged latency.
REQ-029 dz SHALL be 0 after any other completed op.
REQ-030 IDIV of the most negative value by -1 SHALL give result 0x80..0 (the dividend) with dz=0.
REQ-031 Reserved ops SHALL skip RUN (LOAD -> FIX), giving result 0, dz=0, and done at T+2.
REQ-032 kill in LOAD, RUN or FIX SHALL go to IDLE at the next edge, with no done pulse and result/dz unchanged.
REQ-033 kill in IDLE or DONE SHALL have no effect.
REQ-034 kill and start in the same DONE cycle: kill SHALL win (no accept).
REQ-035 In IDLE, busy and done SHALL be 0.

Reset
REQ-036 grst high SHALL immediately force: state IDLE, busy=0, done=0, result=0, dz=0, accumulators cleared, regardless of gclk.
REQ-037 Reset mid-operation SHALL discard the operation; the first start after grst deasserts SHALL be accepted normally.

Verification
REQ-038 MULH opa=0xFFFFFFFF, opb=0x00000002 -> result 0xFFFFFFFF, done at T+10.
REQ-039 MULHU, same operands -> result 0x00000001.
REQ-040 MUL opa=7, opb=6 -> result 0x0000002A, done at T+10.
REQ-041 IDIV opb=0xFFFFFFF9, opa=2 -> result 0xFFFFFFFD, dz=0, done at T+34.
REQ-042 IDIVU opb=100, opa=0 -> result 0, dz=1, done at T+34.
REQ-043 IDIV opb=0x80000000, opa=0xFFFFFFFF -> result 0x80000000, dz=0.
REQ-044 kill asserted at T+5 of a divide -> busy 0 from T+6, no done pulse, result still shows the prior value.
REQ-045 After REQ-044, a new MUL started at T+7 completes correctly at T+17.
REQ-046 grst pulse between edges during RUN -> busy, done, result and dz read 0 before the next gclk edge.
REQ-047 Back-to-back: start asserted in the done cycle of a MUL -> second done exactly ITER+3 cycles after the first.
